ssd_scan_driver: RTL and testbench

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

---
 rtl/ssd_scan_driver_if.sv | 41 ++++
 rtl/ssd_scan_driver.sv | 219 +++++++++++++++++++++
 tb/tb_ssd_scan_driver.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_driver_if.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver_if
// Bundles the control, data and display signals of the multiplexed
// seven-segment scan driver so they travel as a single port.
//
// Signals (direction seen from the driver, i.e. the slave modport):
//   en          in   1 = scanning, 0 = display dark with counters held
//   value       in   hex nibbles, nibble k drives digit k (digit 0 rightmost)
//   dp          in   per-digit decimal point request
//   blank       in   per-digit forced blank
//   lz_en       in   leading-zero suppression enable
//   load        in   single-cycle strobe capturing value/dp/blank
//   SSD         out  segment pins, bit0 = A .. bit6 = G, bit7 = DP
//   d           out  digit enable pins, one-hot while scanning
//   frame_done  out  one-cycle pulse after each frame wrap
// ---------------------------------------------------------------------------
interface ssd_scan_driver_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      en;
   logic [4*NUM_DIGITS-1:0]   value;
   logic [NUM_DIGITS-1:0]     dp;
   logic [NUM_DIGITS-1:0]     blank;
   logic                      lz_en;
   logic                      load;
   logic [7:0]                SSD;
   logic [NUM_DIGITS-1:0]     d;
   logic                      frame_done;

   // Host / testbench side: drives the controls, observes the pins.
   modport master (
      output en, value, dp, blank, lz_en, load,
      input  SSD, d, frame_done
   );

   // Driver side.
   modport slave (
      input  en, value, dp, blank, lz_en, load,
      output SSD, d, frame_done
   );
endinterface

// File: rtl/ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver
// Time-multiplexed seven-segment display driver. A prescaler divides clk so
// that each digit stays lit for SCAN_DIV cycles; a digit index walks through
// the digits and one full pass is a frame. New data is loaded into a pending
// register at any time and only moves into the display register at a frame
// wrap, so a frame is never torn. Supports per-digit decimal points, forced
// blanking and leading-zero suppression. Segment and digit outputs are
// registered (one cycle after the index / display register they reflect).
//
// Parameters:
//   NUM_DIGITS      number of multiplexed digits (1..8)
//   SCAN_DIV        clock cycles per digit (>= 2)
//   SEG_ACTIVE_LOW  1 = invert SSD and d at the pins
//
// Ports:
//   clk    in   clock, all state changes on the rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of ssd_scan_driver_if (controls, data, pins)
// ---------------------------------------------------------------------------
module ssd_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 100000,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   ssd_scan_driver_if.slave   bus
);

   localparam int PRESC_W = $clog2(SCAN_DIV);
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int VAL_W   = 4 * NUM_DIGITS;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   // Segment pattern (bits G..A) for one hex nibble.
   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'h3F;
         4'h1:    g = 7'h06;
         4'h2:    g = 7'h5B;
         4'h3:    g = 7'h4F;
         4'h4:    g = 7'h66;
         4'h5:    g = 7'h6D;
         4'h6:    g = 7'h7D;
         4'h7:    g = 7'h07;
         4'h8:    g = 7'h7F;
         4'h9:    g = 7'h6F;
         4'hA:    g = 7'h77;
         4'hB:    g = 7'h7C;
         4'hC:    g = 7'h39;
         4'hD:    g = 7'h5E;
         4'hE:    g = 7'h79;
         4'hF:    g = 7'h71;
         default: g = 7'h00;
      endcase
      return g;
   endfunction

   // Timing state
   logic [PRESC_W-1:0]    presc_r;
   logic [IDX_W-1:0]      idx_r;
   logic                  tick_s;
   logic                  wrap_s;

   // Pending and display registers
   logic [VAL_W-1:0]      pend_value_r;
   logic [NUM_DIGITS-1:0] pend_dp_r;
   logic [NUM_DIGITS-1:0] pend_blank_r;
   logic                  pend_valid_r;
   logic [VAL_W-1:0]      disp_value_r;
   logic [NUM_DIGITS-1:0] disp_dp_r;
   logic [NUM_DIGITS-1:0] disp_blank_r;

   // Output path
   logic [NUM_DIGITS-1:0] sup_s;
   logic [3:0]            cur_nib_s;
   logic                  cur_dp_s;
   logic                  cur_blank_s;
   logic                  cur_sup_s;
   logic [7:0]            seg_next_s;
   logic [NUM_DIGITS-1:0] dig_next_s;
   logic [7:0]            seg_r;
   logic [NUM_DIGITS-1:0] dig_r;
   logic                  frame_done_r;

   // tick only exists while enabled, so a disabled driver freezes both counters.
   assign tick_s = bus.en & (presc_r == PRESC_LAST);
   assign wrap_s = tick_s & (idx_r == IDX_LAST);

   // Prescaler: counts cycles spent on the current digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_r <= {PRESC_W{1'b0}};
      end else if (tick_s) begin
         presc_r <= {PRESC_W{1'b0}};
      end else if (bus.en) begin
         presc_r <= presc_r + PRESC_W'(1);
      end else begin
         presc_r <= presc_r;
      end
   end

   // Digit index: advances on each tick, returns to 0 at the frame wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r <= {IDX_W{1'b0}};
      end else if (wrap_s) begin
         idx_r <= {IDX_W{1'b0}};
      end else if (tick_s) begin
         idx_r <= idx_r + IDX_W'(1);
      end else begin
         idx_r <= idx_r;
      end
   end

   // Pending / display registers. A load landing on the wrap cycle bypasses
   // the pending stage so it is not delayed a whole frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_value_r <= {VAL_W{1'b0}};
         pend_dp_r    <= {NUM_DIGITS{1'b0}};
         pend_blank_r <= {NUM_DIGITS{1'b0}};
         pend_valid_r <= 1'b0;
         disp_value_r <= {VAL_W{1'b0}};
         disp_dp_r    <= {NUM_DIGITS{1'b0}};
         disp_blank_r <= {NUM_DIGITS{1'b0}};
      end else if (bus.load && wrap_s) begin
         disp_value_r <= bus.value;
         disp_dp_r    <= bus.dp;
         disp_blank_r <= bus.blank;
         pend_valid_r <= 1'b0;
      end else if (bus.load) begin
         pend_value_r <= bus.value;
         pend_dp_r    <= bus.dp;
         pend_blank_r <= bus.blank;
         pend_valid_r <= 1'b1;
      end else if (wrap_s && pend_valid_r) begin
         disp_value_r <= pend_value_r;
         disp_dp_r    <= pend_dp_r;
         disp_blank_r <= pend_blank_r;
         pend_valid_r <= 1'b0;
      end else begin
         pend_valid_r <= pend_valid_r;
      end
   end

   // Leading-zero map: digit k is suppressed when it and every digit to its
   // left hold 0. Digit 0 is never suppressed so a zero value still shows '0'.
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      sup_s    = {NUM_DIGITS{1'b0}};
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_run = zero_run & (disp_value_r[4*k +: 4] == 4'h0);
         sup_s[k] = bus.lz_en & zero_run;
      end
   end

   // Select the current digit's data and build its segment pattern.
   always_comb begin
      cur_nib_s   = 4'h0;
      cur_dp_s    = 1'b0;
      cur_blank_s = 1'b0;
      cur_sup_s   = 1'b0;
      dig_next_s  = {NUM_DIGITS{1'b0}};
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_r == IDX_W'(k)) begin
            cur_nib_s     = disp_value_r[4*k +: 4];
            cur_dp_s      = disp_dp_r[k];
            cur_blank_s   = disp_blank_r[k];
            cur_sup_s     = sup_s[k];
            dig_next_s[k] = 1'b1;
         end else begin
            dig_next_s[k] = 1'b0;
         end
      end
      // Blank wins over everything; suppression keeps only the decimal point.
      if (cur_blank_s) begin
         seg_next_s = 8'h00;
      end else if (cur_sup_s) begin
         seg_next_s = {cur_dp_s, 7'h00};
      end else begin
         seg_next_s = {cur_dp_s, glyph(cur_nib_s)};
      end
   end

   // Output registers, held dark while the scan is disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_r <= 8'h00;
         dig_r <= {NUM_DIGITS{1'b0}};
      end else if (bus.en) begin
         seg_r <= seg_next_s;
         dig_r <= dig_next_s;
      end else begin
         seg_r <= 8'h00;
         dig_r <= {NUM_DIGITS{1'b0}};
      end
   end

   // Frame pulse: high for the single cycle following a wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done_r <= 1'b0;
      end else begin
         frame_done_r <= wrap_s;
      end
   end

   // Polarity is applied only at the pins; the logical state is unchanged.
   assign bus.SSD        = seg_r ^ {8{SEG_ACTIVE_LOW}};
   assign bus.d          = dig_r ^ {NUM_DIGITS{SEG_ACTIVE_LOW}};
   assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_driver
// Directed bench for ssd_scan_driver with NUM_DIGITS=4, SCAN_DIV=4.
// dut_a is active-high and carries most of the sequence; dut_b is
// active-low and covers pin inversion and mid-frame reset.
// ---------------------------------------------------------------------------
module tb_ssd_scan_driver;

   logic clk;
   logic rst_n;
   logic rst_nb;
   int   n_vec;
   int   n_err;

   ssd_scan_driver_if #(.NUM_DIGITS(4)) bus_a ();
   ssd_scan_driver_if #(.NUM_DIGITS(4)) bus_b ();

   ssd_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   ssd_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_b (
      .clk   (clk),
      .rst_n (rst_nb),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Step until frame_done of the chosen DUT is seen (at most 40 cycles).
   task automatic wait_fd(input string tag, input bit use_b);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         step(1);
         if (use_b) got = bus_b.frame_done;
         else       got = bus_a.frame_done;
      end
      chk(tag, {31'd0, got}, 32'd1);
   endtask

   // One full frame of dut_a starting right after a wrap edge. s0..s3 are the
   // expected segments for digits 0..3; an optional load is issued on cycle
   // load_at of the frame.
   task automatic run_frame(input string tag,
                            input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3,
                            input int load_at, input logic [15:0] lv,
                            input logic [3:0] ldp, input logic [3:0] lbl);
      logic [7:0] s [4];
      logic [3:0] ed;
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      for (int i = 0; i < 16; i++) begin
         if (i == load_at) begin
            bus_a.value = lv;
            bus_a.dp    = ldp;
            bus_a.blank = lbl;
            bus_a.load  = 1'b1;
         end
         step(1);
         bus_a.load = 1'b0;
         ed = 4'b0001 << (i / 4);
         chk($sformatf("%s_d%0d", tag, i),   {28'd0, bus_a.d},          {28'd0, ed});
         chk($sformatf("%s_seg%0d", tag, i), {24'd0, bus_a.SSD},        {24'd0, s[i/4]});
         chk($sformatf("%s_fd%0d", tag, i),  {31'd0, bus_a.frame_done}, {31'd0, (i == 15)});
      end
   endtask

   initial begin
      logic [7:0] tbl [4];
      logic [3:0] ed;
      int         dig;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      rst_nb = 1'b0;
      bus_a.en = 1'b0; bus_a.value = 16'h0000; bus_a.dp = 4'h0; bus_a.blank = 4'h0;
      bus_a.lz_en = 1'b0; bus_a.load = 1'b0;
      bus_b.en = 1'b0; bus_b.value = 16'h0000; bus_b.dp = 4'h0; bus_b.blank = 4'h0;
      bus_b.lz_en = 1'b0; bus_b.load = 1'b0;

      // Reset state
      #1;
      chk("rst_a_seg", {24'd0, bus_a.SSD}, 32'h00);
      chk("rst_a_d",   {28'd0, bus_a.d},   32'h0);
      chk("rst_a_fd",  {31'd0, bus_a.frame_done}, 32'h0);
      chk("rst_b_seg", {24'd0, bus_b.SSD}, 32'hFF);
      chk("rst_b_d",   {28'd0, bus_b.d},   32'hF);
      step(2);
      rst_n = 1'b1;
      bus_a.en = 1'b1;
      step(2);
      chk("boot_seg", {24'd0, bus_a.SSD}, 32'h3F);
      chk("boot_d",   {28'd0, bus_a.d},   32'h1);

      // Load 12AF mid-frame, it shows from the next frame
      bus_a.value = 16'h12AF; bus_a.load = 1'b1;
      step(1);
      bus_a.load = 1'b0;
      wait_fd("sync1", 1'b0);
      run_frame("f12af", 8'h71, 8'h77, 8'h5B, 8'h06, -1, 16'h0, 4'h0, 4'h0);

      // Leading-zero suppression
      bus_a.lz_en = 1'b1;
      run_frame("fold",  8'h71, 8'h77, 8'h5B, 8'h06, 0, 16'h0030, 4'h0, 4'h0);
      run_frame("lz30",  8'h3F, 8'h4F, 8'h00, 8'h00, 0, 16'h0000, 4'h0, 4'h0);
      run_frame("lz0",   8'h3F, 8'h00, 8'h00, 8'h00, -1, 16'h0, 4'h0, 4'h0);

      // Mid-frame load at idx=1, then load on the wrap cycle, then 2 cycles later
      run_frame("mid",   8'h3F, 8'h00, 8'h00, 8'h00, 5, 16'h1111, 4'h0, 4'h0);
      run_frame("n1111", 8'h06, 8'h06, 8'h06, 8'h06, 15, 16'h2345, 4'h0, 4'h0);
      run_frame("w2345", 8'h6D, 8'h66, 8'h4F, 8'h5B, 1, 16'h6789, 4'h0, 4'h0);
      run_frame("s6789", 8'h6F, 8'h7F, 8'h07, 8'h7D, 0, 16'h1234, 4'b0110, 4'b0100);

      // Blank/dp frame, with an en=0 pause inside digit 1
      tbl[0] = 8'h66; tbl[1] = 8'hCF; tbl[2] = 8'h00; tbl[3] = 8'h06;
      for (int i = 0; i < 6; i++) begin
         step(1);
         ed = 4'b0001 << (i / 4);
         chk($sformatf("pre_d%0d", i),   {28'd0, bus_a.d},   {28'd0, ed});
         chk($sformatf("pre_seg%0d", i), {24'd0, bus_a.SSD}, {24'd0, tbl[i/4]});
      end
      bus_a.en = 1'b0;
      for (int j = 0; j < 10; j++) begin
         if (j == 3) begin
            bus_a.value = 16'hFEDC; bus_a.dp = 4'h0; bus_a.blank = 4'h0; bus_a.load = 1'b1;
         end
         step(1);
         bus_a.load = 1'b0;
         chk($sformatf("off_d%0d", j),   {28'd0, bus_a.d},   32'h0);
         chk($sformatf("off_seg%0d", j), {24'd0, bus_a.SSD}, 32'h00);
         chk($sformatf("off_fd%0d", j),  {31'd0, bus_a.frame_done}, 32'h0);
      end
      bus_a.en = 1'b1;
      for (int j = 0; j < 10; j++) begin
         step(1);
         dig = 1 + (2 + j) / 4;
         ed = 4'b0001 << dig;
         chk($sformatf("res_d%0d", j),   {28'd0, bus_a.d},   {28'd0, ed});
         chk($sformatf("res_seg%0d", j), {24'd0, bus_a.SSD}, {24'd0, tbl[dig]});
         chk($sformatf("res_fd%0d", j),  {31'd0, bus_a.frame_done}, {31'd0, (j == 9)});
      end
      run_frame("fedc", 8'h39, 8'h5E, 8'h79, 8'h71, -1, 16'h0, 4'h0, 4'h0);

      // Active-low DUT: async reset mid-frame discards a pending load
      rst_nb = 1'b1;
      bus_b.en = 1'b1;
      step(2);
      chk("b_boot_seg", {24'd0, bus_b.SSD}, 32'hC0);
      chk("b_boot_d",   {28'd0, bus_b.d},   32'hE);
      bus_b.value = 16'h0008; bus_b.load = 1'b1;
      step(1);
      bus_b.load = 1'b0;
      #3;
      rst_nb = 1'b0;
      #1;
      chk("b_arst_seg", {24'd0, bus_b.SSD}, 32'hFF);
      chk("b_arst_d",   {28'd0, bus_b.d},   32'hF);
      step(1);
      chk("b_hold_seg", {24'd0, bus_b.SSD}, 32'hFF);
      rst_nb = 1'b1;
      step(2);
      chk("b_rel_seg", {24'd0, bus_b.SSD}, 32'hC0);
      chk("b_rel_d",   {28'd0, bus_b.d},   32'hE);
      wait_fd("b_sync", 1'b1);
      step(1);
      chk("b_nf_seg", {24'd0, bus_b.SSD}, 32'hC0);
      chk("b_nf_d",   {28'd0, bus_b.d},   32'hE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
